// File: rtl/dutycycle_ctrl_pkg.sv
// Shared types and helpers for the duty-cycle divider controller.
package dutycycle_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  localparam int MIN_DIV = 2;

  // High time of a period: odd divisors get the extra cycle in the high phase.
  function automatic logic [31:0] half_ceil(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/dutycycle_ctrl_if.sv
// Divisor configuration port: valid/ready transfer plus a reject pulse.
interface dutycycle_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);
endinterface

// File: rtl/div_phase_gen.sv
// Period counter and registered divided waveform for the currently applied divisor.
module div_phase_gen
  import dutycycle_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] div,
  output logic             clk_out,
  output logic             period_done
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic             active;
  logic             last;

  assign last        = (cnt == div - WIDTH'(1));
  assign period_done = active && last;
  assign cnt_inc     = cnt + WIDTH'(1);

  // A fresh start and a period wrap both begin at cnt=0, which is always high.
  always_ff @(posedge clk) begin
    if (!reset || !run) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      active  <= 1'b0;
    end else if (!active || last) begin
      cnt     <= '0;
      clk_out <= 1'b1;
      active  <= 1'b1;
    end else begin
      cnt     <= cnt_inc;
      clk_out <= (32'(cnt_inc) < half_ceil(32'(div)));
    end
  end

endmodule

// File: rtl/dutycycle_ctrl.sv
// Start/stop sequencing and glitch-free divisor updates for the 50%-duty clock divider.
module dutycycle_ctrl
  import dutycycle_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  dutycycle_ctrl_if.slave  cfg,
  output logic             clk_out,
  output logic             period_done,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] div_cur;
  logic [WIDTH-1:0] div_nxt;
  logic             pend;
  logic             xfer;
  logic             div_ok;
  logic             run;

  assign cfg.cfg_ready = !pend;
  assign xfer          = cfg.cfg_valid && !pend;
  assign div_ok        = (cfg.cfg_div >= WIDTH'(MIN_DIV));
  assign busy          = (state != IDLE);
  assign run           = (state_nxt != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP: begin
        if (en) begin
          state_nxt = RUN;
        end else if (period_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A divisor left pending by a transfer in the final boundary is applied once idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cur     <= WIDTH'(DEFAULT_DIV);
      div_nxt     <= '0;
      pend        <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= xfer && !div_ok;
      if (pend && (period_done || state == IDLE)) begin
        div_cur <= div_nxt;
        pend    <= 1'b0;
      end
      if (xfer && div_ok) begin
        if (state == IDLE) begin
          div_cur <= cfg.cfg_div;
        end else begin
          div_nxt <= cfg.cfg_div;
          pend    <= 1'b1;
        end
      end
    end
  end

  div_phase_gen #(
    .WIDTH(WIDTH)
  ) u_phase (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .div        (div_cur),
    .clk_out    (clk_out),
    .period_done(period_done)
  );

endmodule

// File: tb/tb_dutycycle_ctrl.sv
// Directed and randomized checks of dutycycle_ctrl against a period-level reference model.
module tb_dutycycle_ctrl;

  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 10;

  logic clk;
  logic reset;
  logic en;
  logic clk_out;
  logic period_done;
  logic busy;

  dutycycle_ctrl_if #(.WIDTH(WIDTH)) cfg_if ();

  dutycycle_ctrl #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cfg        (cfg_if),
    .clk_out    (clk_out),
    .period_done(period_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: running/stopping flags, position in period, divisor and a pending queue.
  bit          m_run      = 1'b0;
  bit          m_stopping = 1'b0;
  int unsigned m_pos      = 0;
  int unsigned m_n        = DEFAULT_DIV;
  int unsigned m_q[$];
  bit          m_err      = 1'b0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0b expected %0b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_count(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check_bit("clk_out", clk_out, m_run && (m_pos < (m_n + 1) / 2));
    check_bit("period_done", period_done, m_run && (m_pos == m_n - 1));
    check_bit("busy", busy, m_run);
    check_bit("cfg_ready", cfg_if.cfg_ready, m_q.size() == 0);
    check_bit("cfg_err", cfg_if.cfg_err, m_err);
  endtask

  task automatic apply_stimulus(input logic r, input logic e, input logic v, input int unsigned d);
    reset            = r;
    en               = e;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_div   = WIDTH'(d);
  endtask

  task automatic tick();
    bit          bnd;
    bit          xfer;
    int unsigned nn;
    int unsigned d;
    @(posedge clk);
    bnd  = m_run && (m_pos == m_n - 1);
    xfer = cfg_if.cfg_valid && (m_q.size() == 0);
    d    = int'(cfg_if.cfg_div);
    if (!reset) begin
      m_run      = 1'b0;
      m_stopping = 1'b0;
      m_pos      = 0;
      m_n        = DEFAULT_DIV;
      m_q.delete();
      m_err      = 1'b0;
    end else begin
      m_err = xfer && (d < 2);
      nn    = m_n;
      if (m_q.size() != 0 && (bnd || !m_run)) nn = m_q.pop_front();
      if (xfer && d >= 2) begin
        if (m_run) m_q.push_back(d);
        else nn = d;
      end
      if (!m_run) begin
        if (en) begin
          m_run = 1'b1;
          m_pos = 0;
        end
      end else if (bnd && m_stopping && !en) begin
        m_run = 1'b0;
        m_pos = 0;
      end else begin
        m_pos = bnd ? 0 : m_pos + 1;
      end
      m_stopping = m_run && !en;
      m_n        = nn;
    end
    #1;
    check_output();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int highs;
    int dones;

    apply_stimulus(1'b0, 1'b0, 1'b0, 0);
    ticks(2);

    $display("[TB] default divisor run");
    apply_stimulus(1'b1, 1'b1, 1'b0, 0);
    highs = 0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      highs += int'(clk_out);
      dones += int'(period_done);
    end
    check_count("n10_high_cycles", highs, 10);
    check_count("n10_period_done", dones, 2);

    $display("[TB] stop at end of period");
    apply_stimulus(1'b1, 1'b0, 1'b0, 0);
    ticks(12);

    $display("[TB] idle write N=7");
    apply_stimulus(1'b1, 1'b0, 1'b1, 7);
    tick();
    apply_stimulus(1'b1, 1'b1, 1'b0, 0);
    highs = 0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      highs += int'(clk_out);
      dones += int'(period_done);
    end
    check_count("n7_high_cycles", highs, 8);
    check_count("n7_period_done", dones, 2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 0);
    ticks(9);

    $display("[TB] running update to N=4");
    apply_stimulus(1'b1, 1'b0, 1'b1, 10);
    tick();
    apply_stimulus(1'b1, 1'b1, 1'b0, 0);
    ticks(4);
    apply_stimulus(1'b1, 1'b1, 1'b1, 4);
    tick();
    apply_stimulus(1'b1, 1'b1, 1'b0, 0);
    ticks(16);

    $display("[TB] rejected divisors");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1);
    tick();
    apply_stimulus(1'b1, 1'b1, 1'b1, 0);
    tick();
    apply_stimulus(1'b1, 1'b1, 1'b0, 0);
    ticks(6);

    $display("[TB] stop and re-enable mid-period");
    apply_stimulus(1'b1, 1'b0, 1'b1, 10);
    ticks(10);
    apply_stimulus(1'b1, 1'b1, 1'b0, 0);
    ticks(3);
    apply_stimulus(1'b1, 1'b0, 1'b0, 0);
    ticks(4);
    apply_stimulus(1'b1, 1'b1, 1'b0, 0);
    ticks(12);

    $display("[TB] reset with pending divisor");
    apply_stimulus(1'b1, 1'b1, 1'b1, 6);
    tick();
    apply_stimulus(1'b1, 1'b1, 1'b0, 0);
    ticks(2);
    apply_stimulus(1'b0, 1'b1, 1'b0, 0);
    tick();
    apply_stimulus(1'b1, 1'b1, 1'b0, 0);
    ticks(22);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 4000; i++) begin
      bit mostly_on;
      mostly_on = ((i / 200) % 2) == 0;
      apply_stimulus($urandom_range(0, 149) != 0,
                     mostly_on ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0),
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 13));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dutycycle_ctrl.md
Name: dutycycle_ctrl

Overview:
Runtime controller for the 50%-duty clock divider. It owns the divide counter and sequences start and stop, so the output only ever changes on a period boundary and never emits a runt pulse. Divisor updates arrive over a valid/ready config port and are applied glitch-free at the next period boundary. It sits between the config register block and any logic that consumes the divided clock or enable.

Parameters:
WIDTH, 8, width of the divisor and internal counter
DEFAULT_DIV, 10, divisor loaded at reset; must satisfy 2 <= DEFAULT_DIV < 2**WIDTH

Ports:
clk  input  1  single system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets at the next rising clk edge)
en  input  1  level; 1 = run divider, 0 = stop at end of current period
cfg_valid  input  1  new divisor offered
cfg_div  input  WIDTH  offered divisor N
cfg_ready  output  1  controller can accept a divisor this cycle
cfg_err  output  1  one-cycle pulse: offered divisor rejected (N<2)
clk_out  output  1  registered divided waveform
period_done  output  1  one-cycle pulse in the last cycle of each period
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset values: clk_out=0, period_done=0, cfg_err=0, busy=0, cfg_ready=1, state=IDLE, cnt=0, div_cur=DEFAULT_DIV, pend=0.
- Reset mid-operation takes effect at the next edge: the period is aborted, clk_out goes to 0, and any pending divisor is discarded.
- Waveform for divisor N: high time H=ceil(N/2), low time N-H.
  - Even N gives exact 50% duty; odd N gives one extra high cycle (e.g. N=7 is 4 high, 3 low).
  - cnt runs 0..N-1; clk_out=1 while cnt<H.
  - Wrap rule: cnt==N-1 returns cnt to 0 on the next edge.
- States:
  - IDLE: clk_out=0. On en=1, the next edge enters RUN with cnt=0 and clk_out=1. The first high cycle follows the sampling edge, so latency is 1 cycle.
  - RUN: count. If en=0 is sampled, the next edge enters STOP and counting continues.
  - STOP: finish the current period. At cnt==N-1 the next edge enters IDLE with clk_out=0. If en=1 is sampled before then, return to RUN with no phase disturbance.
- period_done=1 exactly in the cycle where cnt==N-1, in RUN or STOP.
- Config handshake:
  - cfg_ready = !pend. A transfer occurs when cfg_valid && cfg_ready.
  - In IDLE, a valid transfer writes div_cur on the next edge.
  - In RUN or STOP, a transfer stores div_nxt and sets pend=1. At the period boundary (cnt==N-1), div_cur<=div_nxt and pend<=0, and the new period starts with the new N.
  - A transfer in the boundary cycle itself is stored and applied at the following boundary, not the current one.
  - Transfer with cfg_div<2: cfg_err=1 for one cycle, nothing stored, pend unchanged.
  - cfg_valid while cfg_ready=0 is ignored and produces no error. The requester holds cfg_valid until ready.
- Simultaneous events at a boundary: en=0 in STOP plus pend: the divisor is applied and the state goes to IDLE on the same edge.
- en toggling every cycle must never shorten a high or low phase below its programmed length.

Decomposition:
- Package dutycycle_ctrl_pkg holds:
  - the state enum (IDLE, RUN, STOP);
  - localparam MIN_DIV=2;
  - a function computing H=ceil(N/2).
- One sub-module, div_phase_gen, contains cnt, the H/N compare, clk_out and period_done.
  - Inputs: clk, reset, run, div.
  - dutycycle_ctrl keeps the FSM, the pend/div_nxt logic and the handshake.

Test Plan:
- Reset, then en=1 with default N=10 -> clk_out 5 high / 5 low repeating; period_done every 10 cycles, aligned with the 5th low cycle; busy=1.
- In IDLE, write cfg_div=7, then en=1 -> 4 high / 3 low; period_done every 7 cycles.
- RUN N=10, write cfg_div=4 at cnt=3 -> cfg_ready low until the boundary; current period completes 5/5; next periods are 2/2; cfg_ready back to 1.
- Write cfg_div=1, then cfg_div=0 -> cfg_err pulses once each; waveform and div_cur unchanged; cfg_ready stays 1.
- RUN N=10, en=0 at cnt=2 -> the period completes (5 high, 5 low), then clk_out=0 and busy=0. Repeat, re-asserting en at cnt=6 -> no gap, period continues unchanged.
- RUN N=10 with a pending cfg_div=6: assert reset=0 for one cycle at cnt=4 -> next edge clk_out=0, busy=0, pend=0. Then en=1 -> 5/5 waveform (DEFAULT_DIV restored).
